// File: rtl/report_framer_if.sv
// UART transmit handshake between the report framer and the dispatcher's TX.
// The framer drives a one-cycle transmit strobe with a byte; the UART answers
// with busy for the duration of the byte on the line.
interface report_framer_if #(
  parameter int DATA_BW = 8
);
  logic               transmit;
  logic [DATA_BW-1:0] data;
  logic               busy;

  modport master (
    output transmit,
    output data,
    input  busy
  );

  modport slave (
    input  transmit,
    input  data,
    output busy
  );
endinterface

// File: rtl/report_framer.sv
// Patient-status report framer.
// On a start request every input is snapshotted, the binary level is turned
// into three BCD digits by a sequential double-dabble (one shift per cycle),
// and a fixed 17-byte ASCII line "HH:MM L=CCC S=G\r\n" is handed to the UART
// one byte at a time using the transmit/busy handshake.
module report_framer #(
  parameter int MAXB    = 9,
  parameter int DATAORE = 4,
  parameter int STAGE   = 3,
  parameter int DATA_BW = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MAXB-1:0]    livello,
  input  logic [DATAORE-1:0] o_dore,
  input  logic [DATAORE-1:0] o_ore,
  input  logic [DATAORE-1:0] o_dmin,
  input  logic [DATAORE-1:0] o_min,
  input  logic [STAGE-1:0]   stage,
  report_framer_if.master    uart,
  output logic               frame_busy,
  output logic               done
);

  localparam int CNT_W = $clog2(MAXB + 1);
  localparam logic [4:0] LAST_IDX = 5'd16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONV    = 3'd1,
    SEND    = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t state;
  state_t state_next;

  // Control
  logic             armed;
  logic [CNT_W-1:0] conv_cnt;
  logic [4:0]       idx;
  logic             accept;
  logic             conv_last;
  logic             advance;

  // Snapshot and conversion registers
  logic [DATAORE-1:0] snap_dore;
  logic [DATAORE-1:0] snap_ore;
  logic [DATAORE-1:0] snap_dmin;
  logic [DATAORE-1:0] snap_min;
  logic [STAGE-1:0]   snap_stage;
  logic [MAXB-1:0]    bin;
  logic [11:0]        bcd;
  logic [11:0]        bcd_adj;
  logic [DATA_BW-1:0] data_q;

  // A time digit outside 0..9 is not a valid BCD digit and is shown as '?'.
  function automatic logic [7:0] digit_char(input logic [DATAORE-1:0] d);
    logic [7:0] c;
    if (d > DATAORE'(9)) c = 8'h3F;
    else                 c = 8'h30 + 8'(d);
    return c;
  endfunction

  // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
  function automatic logic [11:0] bcd_adjust(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Byte of the fixed-format line at position i, built from the snapshot.
  function automatic logic [7:0] frame_byte(input logic [4:0] i);
    logic [7:0] b;
    case (i)
      5'd0:    b = digit_char(snap_dore);
      5'd1:    b = digit_char(snap_ore);
      5'd2:    b = 8'h3A;
      5'd3:    b = digit_char(snap_dmin);
      5'd4:    b = digit_char(snap_min);
      5'd5:    b = 8'h20;
      5'd6:    b = 8'h4C;
      5'd7:    b = 8'h3D;
      5'd8:    b = {4'h3, bcd[11:8]};
      5'd9:    b = {4'h3, bcd[7:4]};
      5'd10:   b = {4'h3, bcd[3:0]};
      5'd11:   b = 8'h20;
      5'd12:   b = 8'h53;
      5'd13:   b = 8'h3D;
      5'd14:   b = 8'h30 + 8'(snap_stage);
      5'd15:   b = 8'h0D;
      5'd16:   b = 8'h0A;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // A start on the very first edge after reset release is not accepted,
  // so armed keeps the framer deaf for that single cycle.
  assign accept    = (state == IDLE) && start && armed;
  assign conv_last = (conv_cnt == CNT_W'(MAXB - 1));
  assign advance   = (state == WAIT_LO) && !uart.busy && (idx != LAST_IDX);
  assign bcd_adj   = bcd_adjust(bcd);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic: conversion, then a send/wait-high/wait-low loop per byte.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)      state_next = CONV;
      CONV:    if (conv_last)   state_next = SEND;
      SEND:    if (!uart.busy)  state_next = WAIT_HI;
      WAIT_HI: if (uart.busy)   state_next = WAIT_LO;
      WAIT_LO: begin
        if (!uart.busy) state_next = (idx == LAST_IDX) ? DONE : SEND;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state; the strobe is withheld while the UART is busy.
  always_comb begin
    uart.transmit = (state == SEND) && !uart.busy;
    frame_busy    = (state == CONV) || (state == SEND) ||
                    (state == WAIT_HI) || (state == WAIT_LO);
    done          = (state == DONE);
  end

  // Arm start acceptance one cycle after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) armed <= 1'b0;
    else      armed <= 1'b1;
  end

  // Snapshot on accepted start, then one double-dabble shift per CONV cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_dore  <= '0;
      snap_ore   <= '0;
      snap_dmin  <= '0;
      snap_min   <= '0;
      snap_stage <= '0;
      bin        <= '0;
      bcd        <= '0;
      conv_cnt   <= '0;
    end else if (accept) begin
      snap_dore  <= o_dore;
      snap_ore   <= o_ore;
      snap_dmin  <= o_dmin;
      snap_min   <= o_min;
      snap_stage <= stage;
      bin        <= livello;
      bcd        <= '0;
      conv_cnt   <= '0;
    end else if (state == CONV) begin
      {bcd, bin} <= {bcd_adj[10:0], bin, 1'b0};
      conv_cnt   <= conv_cnt + 1'b1;
    end
  end

  // Byte index and output byte; the byte is loaded on entry to SEND so it is
  // already stable in the strobe cycle and held until the next strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx    <= '0;
      data_q <= '0;
    end else if (accept) begin
      idx <= '0;
    end else if ((state == CONV) && conv_last) begin
      data_q <= DATA_BW'(frame_byte(5'd0));
    end else if (advance) begin
      idx    <= idx + 5'd1;
      data_q <= DATA_BW'(frame_byte(idx + 5'd1));
    end
  end

  assign uart.data = data_q;

endmodule

// File: tb/tb_report_framer.sv
// Bench for report_framer: directed frames with hand-computed byte lines.
// Stimulus pushes the expected bytes (and a done marker) into a queue; an
// independent monitor pops and compares on every transmit strobe and done.
module tb_report_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [8:0] livello;
  logic [3:0] o_dore, o_ore, o_dmin, o_min;
  logic [2:0] stage;
  logic       frame_busy;
  logic       done;
  logic       uart_busy = 1'b0;
  logic       hold_busy = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int tx_seen  = 0;
  logic       prev_tx = 1'b0;
  logic [8:0] sb[$];

  localparam logic [8:0] DONE_MARK = 9'h100;

  report_framer_if #(.DATA_BW(8)) uif ();
  assign uif.busy = uart_busy | hold_busy;

  report_framer #(
    .MAXB(9), .DATAORE(4), .STAGE(3), .DATA_BW(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .livello(livello),
    .o_dore(o_dore), .o_ore(o_ore), .o_dmin(o_dmin), .o_min(o_min),
    .stage(stage), .uart(uif), .frame_busy(frame_busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare each strobed byte and each done pulse against the queue.
  always @(negedge clk) begin
    if (rst) begin
      if (uif.transmit) begin
        tx_seen++;
        if (prev_tx) check("tx_back_to_back", 1, 0);
        if (uif.busy) check("tx_while_busy", 1, 0);
        if (sb.size() == 0) check("unexpected_byte", {1'b0, uif.data}, 9'h1FF);
        else check("byte", {1'b0, uif.data}, sb.pop_front());
      end
      if (done) begin
        if (sb.size() == 0) check("unexpected_done", DONE_MARK, 9'h1FF);
        else check("done", DONE_MARK, sb.pop_front());
      end
    end
    prev_tx = uif.transmit;
  end

  // UART model: busy rises one cycle after a strobe and lasts 20 cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (uif.transmit) begin
        @(posedge clk); #1 uart_busy = 1'b1;
        repeat (20) @(posedge clk);
        #1 uart_busy = 1'b0;
      end
    end
  end

  task automatic set_inputs(input logic [8:0] lv, input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d, input logic [2:0] s);
    livello = lv; o_dore = a; o_ore = b; o_dmin = c; o_min = d; stage = s;
  endtask

  task automatic push_frame(input logic [135:0] f);
    for (int i = 0; i < 17; i++) sb.push_back({1'b0, f[135-8*i -: 8]});
    sb.push_back(DONE_MARK);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge clk); n++;
    end
    check(name, sb.size(), 0);
    repeat (30) @(posedge clk);
  endtask

  task automatic wait_bytes(input int nb);
    int c, n;
    c = 0; n = 0;
    while (c < nb && n < 3000) begin
      @(negedge clk); n++;
      if (uif.transmit) c++;
    end
    check("wait_bytes_timeout", c, nb);
  endtask

  logic [135:0] f1 = 136'h31323A3334204C3D31333720533D350D0A;
  logic [135:0] f2 = 136'h30393A3539204C3D30303020533D300D0A;
  logic [135:0] f3 = 136'h32333A3539204C3D35313120533D370D0A;
  logic [135:0] f4 = 136'h3F323A333F204C3D31333720533D350D0A;
  logic [135:0] f5 = 136'h30373A3436204C3D30343220533D330D0A;

  initial begin
    int n, bad, base;
    rst = 1'b0; start = 1'b0;
    set_inputs(9'd0, 4'd0, 4'd0, 4'd0, 4'd0, 3'd0);
    #12;
    check("rst_transmit", uif.transmit, 0);
    check("rst_data", uif.data, 0);
    check("rst_frame_busy", frame_busy, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    // Basic frame: 137, 12:34, stage 5
    set_inputs(9'd137, 4'd1, 4'd2, 4'd3, 4'd4, 3'd5);
    push_frame(f1);
    pulse_start();
    drain("frame_137");

    // Level 0 with first-strobe latency and frame_busy rise
    set_inputs(9'd0, 4'd0, 4'd9, 4'd5, 4'd9, 3'd0);
    push_frame(f2);
    @(posedge clk); #1 start = 1'b1;
    check("fb_before_accept", frame_busy, 0);
    n = 0;
    while (n < 50) begin
      @(posedge clk); #1; n++;
      if (n == 1) begin
        start = 1'b0;
        check("fb_after_accept", frame_busy, 1);
      end
      if (uif.transmit) break;
    end
    check("first_tx_latency", n, 10);
    drain("frame_000");

    // Level 511, stage 7
    set_inputs(9'd511, 4'd2, 4'd3, 4'd5, 4'd9, 3'd7);
    push_frame(f3);
    pulse_start();
    drain("frame_511");

    // Invalid time digits become '?'
    set_inputs(9'd137, 4'd15, 4'd2, 4'd3, 4'd12, 3'd5);
    push_frame(f4);
    pulse_start();
    drain("frame_bad_digits");

    // Inputs changed and start re-pulsed mid-frame
    base = tx_seen;
    set_inputs(9'd42, 4'd0, 4'd7, 4'd4, 4'd6, 3'd3);
    push_frame(f5);
    pulse_start();
    wait_bytes(6);
    #1 set_inputs(9'd300, 4'd9, 4'd9, 4'd9, 4'd9, 3'd1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    drain("frame_snapshot");
    check("snapshot_byte_count", tx_seen - base, 17);

    // Busy held high before byte 0
    set_inputs(9'd137, 4'd1, 4'd2, 4'd3, 4'd4, 3'd5);
    push_frame(f1);
    @(posedge clk); #1 hold_busy = 1'b1;
    pulse_start();
    bad = 0;
    repeat (500) begin
      @(posedge clk); #1;
      if (uif.transmit) bad++;
    end
    check("no_tx_while_held", bad, 0);
    hold_busy = 1'b0;
    #1 check("byte0_after_release", uif.transmit, 1);
    drain("frame_after_hold");

    // Reset during byte 8, start at reset release, then a clean frame
    push_frame(f1);
    pulse_start();
    wait_bytes(9);
    #1 rst = 1'b0;
    #1;
    check("midrst_transmit", uif.transmit, 0);
    check("midrst_frame_busy", frame_busy, 0);
    check("midrst_done", done, 0);
    check("midrst_data", uif.data, 0);
    sb.delete();
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    bad = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (frame_busy) bad++;
    end
    check("start_at_release_ignored", bad, 0);
    push_frame(f1);
    pulse_start();
    drain("frame_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/report_framer.md
# report_framer

Formats one patient-status snapshot into a fixed 17-byte ASCII line and feeds it byte by byte to the UART transmitter in the dispatcher, using the same `transmit`/`busy` handshake the system core uses.
- Sits between the system core's display/level outputs (`livello`, `o_dore`/`o_ore`/`o_dmin`/`o_min`, `stage`) and the UART TX input.
- Converts the binary level to decimal internally.
- Snapshots all inputs at request time, so the transmitted line is coherent.

## Interface
Parameters:
- `MAXB`, 9, width of `livello` (binary level)
- `DATAORE`, 4, width of each BCD time digit
- `STAGE`, 3, width of `stage`
- `DATA_BW`, 8, UART byte width

Ports:
- `clk` in 1: system clock, 100 MHz
- `rst` in 1: asynchronous, active-low reset
- `start` in 1: frame request; sampled high for one cycle
- `livello` in MAXB: binary level, 0..511
- `o_dore`, `o_ore`, `o_dmin`, `o_min` in DATAORE each: BCD hour-tens, hour-units, minute-tens, minute-units
- `stage` in STAGE: post-op stage, 0..7
- `busy` in 1: UART transmission in progress
- `transmit` out 1: one-cycle strobe, `data` valid
- `data` out DATA_BW: byte to transmit
- `frame_busy` out 1: high from accepted `start` until `done`
- `done` out 1: one-cycle pulse at frame end

## Operation
- Frame format, exactly 17 bytes in this order: D1 D2 ':' D3 D4 ' ' 'L' '=' C2 C1 C0 ' ' 'S' '=' G CR LF.
  - D1..D4 are ASCII of `o_dore`, `o_ore`, `o_dmin`, `o_min`.
  - C2..C0 are the hundreds, tens and units of `livello`.
  - G = 0x30 + `stage`.
- A time digit greater than 9 is sent as '?' (0x3F). Level always has 3 digits with leading zeros (0 -> "000").
- States:
  - IDLE: `start`=1 latches every data input into snapshot registers and goes to CONV.
  - CONV: sequential double-dabble, one shift per cycle, exactly MAXB cycles. Then SEND with byte index 0.
  - SEND: if `busy`=0, drive `data` from index, pulse `transmit`, go to WAIT_HI. If `busy`=1, hold in SEND.
  - WAIT_HI: wait for `busy`=1, then WAIT_LO.
  - WAIT_LO: wait for `busy`=0. If index=16, go to DONE; otherwise increment index and go to SEND.
  - DONE: `done`=1 for one cycle, then IDLE.
- `start` is ignored in any state other than IDLE; it is not queued.
- Input changes after the snapshot do not affect the frame in progress.
- Byte index is 5 bits and counts 0..16; it never wraps inside a frame.
- BCD correction rule: add 3 to any nibble ≥5 before each shift. The BCD register is 12 bits.

## Timing
- Reset values: `transmit`=0, `data`=0x00, `frame_busy`=0, `done`=0, state IDLE, index 0, snapshot 0.
- `start` high at edge k: CONV from k+1. First `transmit` is high in the cycle after edge k+1+MAXB (k+10 for defaults), provided `busy`=0.
- `frame_busy` rises at edge k+1. It falls together with the `done` pulse.
- `data` is registered. It is stable from the `transmit` cycle until the next `transmit`.
- `transmit` is never high on two consecutive cycles, and never high while `busy`=1.
- Frame length in cycles ≥ 10 + 17×(3 + UART byte time). There is no timeout: `busy` stuck high stalls the frame indefinitely.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous). After release the block is in IDLE and the next `start` sends a complete frame from byte 0.
- `start` coinciding with reset release is ignored.

## Test plan
- `livello`=137, time 1,2,3,4, `stage`=5, UART model raises `busy` 1 cycle after `transmit` and holds it 20 cycles -> bytes 31 32 3A 33 34 20 4C 3D 31 33 37 20 53 3D 35 0D 0A, then one `done` pulse.
- `livello`=0, then a second frame with `livello`=511 -> C2..C0 = "000", then "511". Check the first `transmit` arrives exactly 10 cycles after `start`.
- `o_min`=12, `o_dore`=15 -> bytes 0 and 4 are 0x3F; all other bytes are unchanged.
- Pulse `start` again and change every input at byte 5 -> exactly 17 bytes are sent, all from the original snapshot; the second `start` produces no extra frame.
- Hold `busy`=1 for 500 cycles before byte 0 -> `transmit` stays 0 throughout. Byte 0 is sent the first cycle after `busy` falls.
- Assert `rst`=0 during byte 8 -> `transmit`, `frame_busy` and `done` go 0 at once. A new `start` after release gives a full 17-byte frame from 0x31.
